// File: rtl/regfile_pkg.sv
// Shared widths and the write-back request payload for the register-file
// write-back arbiter slice.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned REG_DATA_W   = 32;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  // One write-back request as presented by a requester
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of write-back requests, register-file write port, issue tracking and
// hazard queries between the pipeline (master) and the arbiter (slave).
interface regfile_wb_arbiter_if;

  logic                                alu_valid;
  logic [regfile_pkg::REG_ADDR_W-1:0]  alu_addr;
  logic [regfile_pkg::REG_DATA_W-1:0]  alu_data;
  logic                                alu_ready;

  logic                                lsu_valid;
  logic [regfile_pkg::REG_ADDR_W-1:0]  lsu_addr;
  logic [regfile_pkg::REG_DATA_W-1:0]  lsu_data;
  logic                                lsu_ready;

  logic                                write_enable;
  logic [regfile_pkg::REG_ADDR_W-1:0]  write_address;
  logic [regfile_pkg::REG_DATA_W-1:0]  write_data;

  logic                                issue_valid;
  logic [regfile_pkg::REG_ADDR_W-1:0]  issue_addr;

  logic [regfile_pkg::REG_ADDR_W-1:0]  rs1_addr;
  logic [regfile_pkg::REG_ADDR_W-1:0]  rs2_addr;
  logic                                rs1_busy;
  logic                                rs2_busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready,
    input  write_enable, write_address, write_data,
    output issue_valid, issue_addr,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready,
    output write_enable, write_address, write_data,
    input  issue_valid, issue_addr,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// issue and cleared when the write commits on the register-file port.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Next busy vector: clear committed register, then set issued one (set wins)
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) set_mask[issue_addr] = 1'b1;
    if (clr_valid) clr_mask[clr_addr] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Hazard lookup; x0 is never busy
  always_comb begin
    rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
    rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: picks one of ALU/LSU per cycle (LSU
// preferred, ALU forced through after STARVE_LIMIT stalled cycles) and
// registers the winner onto the write port. The pending-write scoreboard is
// built only when WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk_in,
  input logic                 rst_in,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t alu_req;
  wb_req_t lsu_req;
  wb_req_t win_req;
  logic    alu_grant;
  logic    lsu_grant;
  logic    accept;
  logic    starved;

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    write_enable_q, write_enable_d;
  logic [REG_ADDR_W-1:0]   write_address_q, write_address_d;
  logic [REG_DATA_W-1:0]   write_data_q, write_data_d;

  // Arbitration: LSU first unless the ALU has waited STARVE_LIMIT cycles
  always_comb begin
    alu_req   = '{valid: bus.alu_valid, addr: bus.alu_addr, data: bus.alu_data};
    lsu_req   = '{valid: bus.lsu_valid, addr: bus.lsu_addr, data: bus.lsu_data};
    starved   = (starve_q == STARVE_CNT_W'(STARVE_LIMIT));
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (!rst_in) begin
      if (lsu_req.valid && !(alu_req.valid && starved)) lsu_grant = 1'b1;
      else if (alu_req.valid)                           alu_grant = 1'b1;
    end
    accept  = alu_grant | lsu_grant;
    win_req = lsu_grant ? lsu_req : alu_req;
  end

  // Starvation counter and write-port next state
  always_comb begin
    starve_d        = '0;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    if (alu_req.valid && !alu_grant) begin
      starve_d = starved ? starve_q : starve_q + STARVE_CNT_W'(1);
    end
    if (accept) begin
      write_enable_d  = (win_req.addr != '0);
      write_address_d = win_req.addr;
      write_data_d    = win_req.data;
    end
  end

  // State registers; reset also discards a write not yet presented
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_q        <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      starve_q        <= starve_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
    end
  end

  assign bus.alu_ready     = alu_grant;
  assign bus.lsu_ready     = lsu_grant;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .issue_valid (bus.issue_valid),
    .issue_addr  (bus.issue_addr),
    .clr_valid   (write_enable_q),
    .clr_addr    (write_address_q),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy)
  );
`else
  assign bus.rs1_busy = 1'b0;
  assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a cycle-level reference
// model (grant rule, wait count, expected write, busy set) kept here.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cnt;
  bit          m_we;
  bit          m_acc;
  bit [4:0]    m_waddr;
  bit [31:0]   m_wdata;
  bit [31:0]   m_busy;
  bit          last_ag, last_lg;

  function automatic void exp_grant(output bit ag, output bit lg);
    ag = 1'b0;
    lg = 1'b0;
    if (rst) return;
    if (bus.alu_valid && bus.lsu_valid) begin
      if (m_cnt >= int'(LIMIT)) ag = 1'b1;
      else                      lg = 1'b1;
    end else if (bus.alu_valid) ag = 1'b1;
    else if (bus.lsu_valid)     lg = 1'b1;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return SB_EN && (a != 5'd0) && m_busy[a];
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge
  task automatic tick();
    bit ag, lg, acc;
    bit [4:0] a;
    bit [31:0] d;
    int n_cnt;
    bit n_we, n_acc;
    bit [4:0] n_waddr;
    bit [31:0] n_wdata, n_busy;
    exp_grant(ag, lg);
    acc = ag | lg;
    a = ag ? bus.alu_addr : bus.lsu_addr;
    d = ag ? bus.alu_data : bus.lsu_data;
    n_we = acc && (a != 5'd0);
    n_acc = acc;
    n_waddr = acc ? a : m_waddr;
    n_wdata = acc ? d : m_wdata;
    n_busy = m_busy;
    if (m_we) n_busy[m_waddr] = 1'b0;
    if (bus.issue_valid && bus.issue_addr != 5'd0) n_busy[bus.issue_addr] = 1'b1;
    n_cnt = (bus.alu_valid && !ag) ? ((m_cnt < int'(LIMIT)) ? m_cnt + 1 : int'(LIMIT)) : 0;
    last_ag = ag;
    last_lg = lg;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_we = 0; m_acc = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
    end else begin
      m_cnt = n_cnt; m_we = n_we; m_acc = n_acc;
      m_waddr = n_waddr; m_wdata = n_wdata; m_busy = n_busy;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_data = 0;
    bus.issue_valid = 0; bus.issue_addr = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.alu_valid = 1; bus.alu_addr = 5'd3;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd4;
    m_cnt = 0; m_we = 0; m_acc = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
    tick();
    tick();
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", bus.write_enable); end
    checks++; if (bus.write_address !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d exp 0", bus.write_address); end
    checks++; if (bus.write_data !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", bus.write_data); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b exp 0", bus.alu_ready); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %b exp 0", bus.lsu_ready); end
    idle_inputs();
    rst = 0;
    tick();
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL rst_release_we: got %b exp 0", bus.write_enable); end
  endtask

  task automatic test_both_valid();
    idle_inputs();
    bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd4; bus.lsu_data = 32'h22;
    bus.issue_valid = 1; bus.issue_addr = 5'd7; bus.rs1_addr = 5'd7;
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL both_lsu_ready: got %b exp 1", bus.lsu_ready); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL both_alu_ready: got %b exp 0", bus.alu_ready); end
    tick();
    bus.lsu_valid = 0; bus.issue_valid = 0;
    checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL both_we: got %b exp 1", bus.write_enable); end
    checks++; if (bus.write_address !== 5'd4) begin errors++; $display("FAIL both_waddr: got %0d exp 4", bus.write_address); end
    checks++; if (bus.write_data !== 32'h22) begin errors++; $display("FAIL both_wdata: got %h exp 22", bus.write_data); end
    checks++; if (bus.rs1_busy !== exp_busy(5'd7)) begin errors++; $display("FAIL issue7_busy: got %b exp %b", bus.rs1_busy, exp_busy(5'd7)); end
    // ALU alone now: accepted
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_alone_ready: got %b exp 1", bus.alu_ready); end
    tick();
    checks++; if (bus.write_address !== 5'd3 || bus.write_data !== 32'h11) begin errors++; $display("FAIL alu_alone_write: got %0d/%h exp 3/11", bus.write_address, bus.write_data); end
    // Release x7 through a commit
    idle_inputs();
    bus.alu_valid = 1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_starvation();
    bit ag, lg;
    idle_inputs();
    bus.alu_valid = 1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA5A5;
    for (int i = 0; i < 6; i++) begin
      bus.lsu_valid = 1;
      bus.lsu_addr = 5'($urandom_range(1, 31));
      bus.lsu_data = $urandom;
      #1;
      exp_grant(ag, lg);
      checks++; if (bus.alu_ready !== ag || bus.alu_ready !== (i == 4)) begin errors++; $display("FAIL starve_alu_ready[%0d]: got %b exp %b", i, bus.alu_ready, ag); end
      checks++; if (bus.lsu_ready !== lg || bus.lsu_ready !== (i != 4)) begin errors++; $display("FAIL starve_lsu_ready[%0d]: got %b exp %b", i, bus.lsu_ready, lg); end
      tick();
      checks++; if (bus.write_address !== m_waddr || bus.write_data !== m_wdata || bus.write_enable !== m_we) begin errors++; $display("FAIL starve_write[%0d]: got %b/%0d/%h exp %b/%0d/%h", i, bus.write_enable, bus.write_address, bus.write_data, m_we, m_waddr, m_wdata); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_zero_addr();
    idle_inputs();
    bus.alu_valid = 1; bus.alu_addr = 5'd0; bus.alu_data = 32'hDEAD;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b exp 1", bus.alu_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL zero_we: got %b exp 0", bus.write_enable); end
    checks++; if (bus.write_address !== 5'd0 || bus.write_data !== 32'hDEAD) begin errors++; $display("FAIL zero_write: got %0d/%h exp 0/dead", bus.write_address, bus.write_data); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
    bus.issue_valid = 1; bus.issue_addr = 5'd5;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.rs1_busy !== exp_busy(5'd5) || bus.rs1_busy !== SB_EN) begin errors++; $display("FAIL sb_set: got %b exp %b", bus.rs1_busy, SB_EN); end
    bus.alu_valid = 1; bus.alu_addr = 5'd5; bus.alu_data = 32'h55;
    tick();
    bus.alu_valid = 0;
    checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL sb_commit_we: got %b exp 1", bus.write_enable); end
    checks++; if (bus.rs1_busy !== exp_busy(5'd5) || bus.rs1_busy !== SB_EN) begin errors++; $display("FAIL sb_hold_during_we: got %b exp %b", bus.rs1_busy, SB_EN); end
    tick();
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_x0: got %b exp 0", bus.rs2_busy); end
    // Re-issue on the same edge that clears
    bus.issue_valid = 1; bus.issue_addr = 5'd5;
    tick();
    bus.issue_valid = 0;
    bus.alu_valid = 1;
    tick();
    bus.alu_valid = 0;
    bus.issue_valid = 1; bus.issue_addr = 5'd5;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.rs1_busy !== exp_busy(5'd5) || bus.rs1_busy !== SB_EN) begin errors++; $display("FAIL sb_set_wins: got %b exp %b", bus.rs1_busy, SB_EN); end
    // Issue to x0 never marks busy
    bus.issue_valid = 1; bus.issue_addr = 5'd0;
    tick();
    bus.issue_valid = 0;
    checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_issue_x0: got %b exp 0", bus.rs2_busy); end
    bus.alu_valid = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.issue_valid = 1; bus.issue_addr = 5'd9; bus.rs1_addr = 5'd9;
    tick();
    bus.issue_valid = 0;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd4; bus.lsu_data = 32'hCAFE;
    tick();
    checks++; if (bus.write_enable !== 1'b1 || bus.rs1_busy !== SB_EN) begin errors++; $display("FAIL mid_pre: got we %b busy %b exp 1 %b", bus.write_enable, bus.rs1_busy, SB_EN); end
    #2;
    rst = 1;
    m_cnt = 0; m_we = 0; m_acc = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
    #1;
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL mid_we_drop: got %b exp 0", bus.write_enable); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_clear: got %b exp 0", bus.rs1_busy); end
    checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b exp 0", bus.lsu_ready); end
    tick();
    idle_inputs();
    bus.rs1_addr = 5'd9;
    rst = 0;
    tick();
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %b exp 0", bus.write_enable); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b exp 0", bus.rs1_busy); end
  endtask

  task automatic test_random();
    bit ag, lg;
    idle_inputs();
    last_ag = 0; last_lg = 0;
    for (int i = 0; i < 300; i++) begin
      if (!(bus.alu_valid && !last_ag)) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_addr  = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      if (!(bus.lsu_valid && !last_lg)) begin
        bus.lsu_valid = ($urandom_range(0, 2) != 0);
        bus.lsu_addr  = 5'($urandom_range(0, 31));
        bus.lsu_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_addr  = 5'($urandom_range(0, 31));
      bus.rs1_addr    = 5'($urandom_range(0, 31));
      bus.rs2_addr    = 5'($urandom_range(0, 31));
      #1;
      exp_grant(ag, lg);
      checks++; if (bus.alu_ready !== ag || bus.lsu_ready !== lg) begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b exp %b%b", i, bus.alu_ready, bus.lsu_ready, ag, lg); end
      checks++; if (bus.rs1_busy !== exp_busy(bus.rs1_addr) || bus.rs2_busy !== exp_busy(bus.rs2_addr)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b%b exp %b%b", i, bus.rs1_busy, bus.rs2_busy, exp_busy(bus.rs1_addr), exp_busy(bus.rs2_addr)); end
      tick();
      checks++; if (bus.write_enable !== m_we) begin errors++; $display("FAIL rnd_we[%0d]: got %b exp %b", i, bus.write_enable, m_we); end
      if (m_acc) begin
        checks++; if (bus.write_address !== m_waddr || bus.write_data !== m_wdata) begin errors++; $display("FAIL rnd_write[%0d]: got %0d/%h exp %0d/%h", i, bus.write_address, bus.write_data, m_waddr, m_wdata); end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_both_valid();
    test_starvation();
    test_zero_addr();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive ALU-stalled cycles after which ALU wins over LSU (range 1..15).
REQ-002 Port: clk_in  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst_in  input  1  asynchronous, active-high reset.
REQ-004 Port: alu_valid  input  1  ALU write-back request.
REQ-005 Port: alu_addr / alu_data  input  5 / 32  ALU destination register and value.
REQ-006 Port: alu_ready  output  1  ALU request accepted this cycle.
REQ-007 Port: lsu_valid  input  1  load-unit write-back request.
REQ-008 Port: lsu_addr / lsu_data  input  5 / 32  LSU destination register and value.
REQ-009 Port: lsu_ready  output  1  LSU request accepted this cycle.
REQ-010 Port: write_enable / write_address / write_data  output  1 / 5 / 32  register-file write port, registered.
REQ-011 Port: issue_valid / issue_addr  input  1 / 5  instruction issued that will write issue_addr.
REQ-012 Port: rs1_addr / rs2_addr  input  5 / 5  source registers under hazard check.
REQ-013 Port: rs1_busy / rs2_busy  output  1 / 1  source has a pending un-committed write.

Function
REQ-014 Transfer occurs when valid and ready are both high; ready is combinational from valid inputs and starvation state, never from ready.
REQ-015 At most one request is accepted per cycle; a requester with valid low never receives ready.
REQ-016 Arbitration: LSU wins when both are valid, unless the starvation counter equals STARVE_LIMIT, in which case ALU wins.
REQ-017 Starvation counter (4 bit): increments when alu_valid is high and alu_ready is low; clears when ALU is accepted or alu_valid is low; saturates at STARVE_LIMIT.
REQ-018 Accepted request appears on write_address/write_data with write_enable high exactly one cycle after acceptance; write_enable is low in cycles following no acceptance.
REQ-019 Accepted writes to address 0 produce write_enable low; write_address and write_data still update.
REQ-020 Requester must hold valid, addr and data stable until accepted; the block holds no request buffer.
REQ-021 Scoreboard: 32 busy bits; issue_valid with nonzero issue_addr sets its bit at the clock edge.
REQ-022 A write committed on the port (write_enable high) clears the busy bit of write_address at the following edge.
REQ-023 Simultaneous set and clear of the same bit: set wins.
REQ-024 rsN_busy is combinational from busy[rsN_addr]; always 0 for address 0.
REQ-025 A busy bit is never set for register 0.

Reset
REQ-026 On rst_in high, asynchronously: write_enable 0, write_address 0, write_data 0, starvation counter 0, all busy bits 0.
REQ-027 While rst_in is high, alu_ready and lsu_ready are 0.
REQ-028 A write registered but not yet presented when reset asserts is discarded; no write_enable pulse follows reset release.

Configuration
REQ-029 Macro WB_SCOREBOARD_EN: when defined, REQ-021..REQ-025 are implemented.
REQ-030 When WB_SCOREBOARD_EN is undefined: no busy storage; rs1_busy and rs2_busy are constant 0; issue_* are ignored; ports remain present.

Structure
REQ-031 Package regfile_pkg holds REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 and the wb_req_t struct (valid, addr, data).
REQ-032 Scoreboard is a sub-module wb_scoreboard, instantiated only under WB_SCOREBOARD_EN.

Verification
REQ-033 Both valid (ALU x3=0x11, LSU x4=0x22): lsu_ready=1, alu_ready=0; next cycle write_enable=1, addr 4, data 0x22.
REQ-034 ALU valid, LSU valid continuously, STARVE_LIMIT=4: ALU accepted on its 5th cycle of valid; counter returns to 0.
REQ-035 ALU write x0=0xDEAD accepted: next cycle write_enable=0, write_address=0.
REQ-036 issue x5, then ALU commits x5: rs1_addr=5 gives rs1_busy=1 until the edge after write_enable; then 0; same-cycle re-issue keeps it 1.
REQ-037 rst_in asserted mid-cycle after LSU accept: write_enable drops immediately; busy bits clear; no write after release.
REQ-038 Build without WB_SCOREBOARD_EN: issue x7, rs1_addr=7 gives rs1_busy=0; arbitration results identical to REQ-033.
